player_motion: RTL



---
 rtl/player_motion_pkg.sv | 38 +++
 rtl/player_anim.sv | 47 ++++
 rtl/player_motion.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/player_motion_pkg.sv
// Shared stage codes, directions, spawn points, screen bounds and FSM type
// for the player motion block.
package player_motion_pkg;

  localparam logic [3:0] STAGE1 = 4'd2;
  localparam logic [3:0] STAGE2 = 4'd4;
  localparam logic [3:0] STAGE3 = 4'd6;

  typedef enum logic [1:0] {
    DirDown  = 2'd0,
    DirLeft  = 2'd1,
    DirRight = 2'd2,
    DirUp    = 2'd3
  } dir_e;

  localparam logic [8:0] SPAWN1_X = 9'd150;
  localparam logic [8:0] SPAWN1_Y = 9'd200;
  localparam logic [8:0] SPAWN2_X = 9'd20;
  localparam logic [8:0] SPAWN2_Y = 9'd115;
  localparam logic [8:0] SPAWN3_X = 9'd150;
  localparam logic [8:0] SPAWN3_Y = 9'd220;

  // Logical screen is 320x240 and the sprite is 10x10.
  localparam int unsigned X_MAX = 310;
  localparam int unsigned Y_MAX = 230;

  typedef enum logic [1:0] {
    StLocked,
    StSpawn,
    StIdle,
    StWalk
  } motion_state_e;

  function automatic logic is_playable(input logic [3:0] stage);
    return (stage == STAGE1) || (stage == STAGE2) || (stage == STAGE3);
  endfunction

endpackage

// File: rtl/player_anim.sv
// Walking animation: divides walking ticks by ANIM_DIV and steps a 2-bit
// frame counter on each wrap. Clear wins over advance.
module player_anim #(
  parameter int unsigned ANIM_DIV = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       advance,
  input  logic       clear,
  output logic [1:0] frame
);

  localparam int unsigned CntW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(ANIM_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      frame_q, frame_d;

  always_comb begin
    cnt_d   = cnt_q;
    frame_d = frame_q;
    if (clear) begin
      cnt_d   = '0;
      frame_d = '0;
    end else if (advance) begin
      if (cnt_q == CntLast) begin
        cnt_d   = '0;
        frame_d = frame_q + 2'd1;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      frame_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
    end
  end

  assign frame = frame_q;

endmodule

// File: rtl/player_motion.sv
// Player position / facing / animation-frame generator, stepped once per
// video-frame tick and re-spawned whenever the game stage changes.
module player_motion #(
  parameter int unsigned STEP     = 2,
  parameter int unsigned ANIM_DIV = 8,
  parameter int unsigned X_MAX    = player_motion_pkg::X_MAX,
  parameter int unsigned Y_MAX    = player_motion_pkg::Y_MAX
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] state,
  input  logic       tick,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_left,
  input  logic       key_right,
  output logic [8:0] player_x,
  output logic [8:0] player_y,
  output logic [3:0] player_state,
  output logic       moving
);

  import player_motion_pkg::*;

  motion_state_e fsm_q, fsm_d;
  logic [3:0]    prev_state_q;
  logic [8:0]    x_q, x_d, y_q, y_d;
  dir_e          dir_q, dir_d, move_dir;
  logic          any_key, do_move, anim_advance, anim_clear;
  logic [1:0]    frame;
  logic [9:0]    x_inc, y_inc;
  logic [8:0]    x_right, x_left, y_down, y_up;

  // Clamped candidate positions; 10-bit sums so the upper bound check can't wrap.
  always_comb begin
    x_inc   = {1'b0, x_q} + 10'(STEP);
    y_inc   = {1'b0, y_q} + 10'(STEP);
    x_right = (x_inc > 10'(X_MAX)) ? 9'(X_MAX) : x_inc[8:0];
    y_down  = (y_inc > 10'(Y_MAX)) ? 9'(Y_MAX) : y_inc[8:0];
    x_left  = ({1'b0, x_q} < 10'(STEP)) ? 9'd0 : x_q - 9'(STEP);
    y_up    = ({1'b0, y_q} < 10'(STEP)) ? 9'd0 : y_q - 9'(STEP);
  end

  assign any_key = key_up | key_down | key_left | key_right;

  always_comb begin
    if (key_up)        move_dir = DirUp;
    else if (key_down) move_dir = DirDown;
    else if (key_left) move_dir = DirLeft;
    else               move_dir = DirRight;
  end

  always_comb begin
    fsm_d        = fsm_q;
    x_d          = x_q;
    y_d          = y_q;
    dir_d        = dir_q;
    do_move      = 1'b0;
    anim_advance = 1'b0;
    anim_clear   = 1'b0;

    // A stage change pre-empts everything else, including a same-cycle tick.
    if (state != prev_state_q) begin
      fsm_d = is_playable(state) ? StSpawn : StLocked;
    end else begin
      unique case (fsm_q)
        StLocked: ;
        StSpawn: begin
          case (state)
            STAGE2: begin
              x_d = SPAWN2_X;
              y_d = SPAWN2_Y;
            end
            STAGE3: begin
              x_d = SPAWN3_X;
              y_d = SPAWN3_Y;
            end
            default: begin
              x_d = SPAWN1_X;
              y_d = SPAWN1_Y;
            end
          endcase
          dir_d      = DirDown;
          anim_clear = 1'b1;
          fsm_d      = StIdle;
        end
        StIdle: begin
          if (tick && any_key) begin
            do_move = 1'b1;
            fsm_d   = StWalk;
          end
        end
        StWalk: begin
          if (tick) begin
            if (any_key) begin
              do_move = 1'b1;
            end else begin
              anim_clear = 1'b1;
              fsm_d      = StIdle;
            end
          end
        end
        default: fsm_d = StLocked;
      endcase
    end

    if (do_move) begin
      dir_d        = move_dir;
      anim_advance = 1'b1;
      unique case (move_dir)
        DirUp:    y_d = y_up;
        DirDown:  y_d = y_down;
        DirLeft:  x_d = x_left;
        DirRight: x_d = x_right;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q        <= StLocked;
      prev_state_q <= '0;
      x_q          <= '0;
      y_q          <= '0;
      dir_q        <= DirDown;
    end else begin
      fsm_q        <= fsm_d;
      prev_state_q <= state;
      x_q          <= x_d;
      y_q          <= y_d;
      dir_q        <= dir_d;
    end
  end

  player_anim #(
    .ANIM_DIV(ANIM_DIV)
  ) u_anim (
    .clk    (clk),
    .rst_n  (rst_n),
    .advance(anim_advance),
    .clear  (anim_clear),
    .frame  (frame)
  );

  assign player_x     = x_q;
  assign player_y     = y_q;
  assign player_state = {dir_q, frame};
  assign moving       = (fsm_q == StWalk);

endmodule
